// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl -- match sequencer for the pong ball datapath.
//
// Decides when the ball is parked, served or moving; issues one-cycle serve
// pulses with a serve direction; keeps both scores and declares a winner.
//
// Optional feature macro: PONG_SPEEDUP_EN
//   defined   : paddle hits during play raise speed by 1 every HITS_PER_STEP
//               hits (saturating at 7); goal or start returns speed to 3.
//   undefined : speed is constant 3 and paddle_hit is ignored.
//
// Ports
//   clk, reset   system clock, asynchronous active-high reset
//   frame_tick   one-cycle pulse per video frame
//   start_btn    synchronised level, rising edge starts a match
//   pause_btn    synchronised level, rising edge toggles pause during play
//   goal_left    ball exited left edge (right player scores)
//   goal_right   ball exited right edge (left player scores)
//   paddle_hit   one-cycle pulse per paddle bounce
//   ball_run     ball may move (level)
//   ball_serve   one-cycle pulse: recentre ball and load serve_dir
//   serve_dir    0 = toward left player, 1 = toward right player
//   score_l/r    player scores
//   speed        ball step in pixels per frame
//   winner       00 none, 01 left, 10 right
//   state        current sequencer state (IDLE0 SERVE1 PLAY2 PAUSE3 OVER4)
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               goal_left,
  input  logic               goal_right,
  input  logic               paddle_hit,
  output logic               ball_run,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         speed,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int unsigned FC_W = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t            st;
  logic              start_q;
  logic              pause_q;
  logic [FC_W-1:0]   fcnt;
  logic              start_edge;
  logic              pause_edge;
  logic              goal_any;
  logic [SCORE_W-1:0] scorer_pts;
  logic              match_won;

`ifdef PONG_SPEEDUP_EN
  localparam int unsigned HC_W = $clog2(HITS_PER_STEP + 1);
  logic [HC_W-1:0] hcnt;
`else
  // paddle_hit and HITS_PER_STEP only matter with the speed-up feature.
  logic unused_hit;
  assign unused_hit = paddle_hit ^ (HITS_PER_STEP == 0);
`endif

  assign state = st;

  always_comb begin
    start_edge = start_btn & ~start_q;
    pause_edge = pause_btn & ~pause_q;
    goal_any   = goal_left | goal_right;
    // goal_left wins a simultaneous double goal, so the right player scores.
    scorer_pts = goal_left ? score_r : score_l;
    match_won  = (scorer_pts + 1'b1) == SCORE_W'(WIN_SCORE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      fcnt       <= '0;
      ball_run   <= 1'b0;
      ball_serve <= 1'b0;
      serve_dir  <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      speed      <= 3'd3;
      winner     <= 2'b00;
`ifdef PONG_SPEEDUP_EN
      hcnt       <= '0;
`endif
    end else begin
      start_q    <= start_btn;
      pause_q    <= pause_btn;
      ball_serve <= 1'b0;
      case (st)
        IDLE, OVER: begin
          ball_run <= 1'b0;
          if (start_edge) begin
            st         <= SERVE;
            score_l    <= '0;
            score_r    <= '0;
            winner     <= 2'b00;
            speed      <= 3'd3;
            fcnt       <= '0;
            ball_serve <= 1'b1;
`ifdef PONG_SPEEDUP_EN
            hcnt       <= '0;
`endif
          end
        end
        SERVE: begin
          ball_run <= 1'b0;
          if (frame_tick) begin
            if (fcnt == FC_W'(SERVE_FRAMES - 1)) begin
              st       <= PLAY;
              ball_run <= 1'b1;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        PLAY: begin
          if (goal_any) begin
            ball_run <= 1'b0;
            speed    <= 3'd3;
`ifdef PONG_SPEEDUP_EN
            hcnt     <= '0;
`endif
            if (goal_left) begin
              serve_dir <= 1'b0;
              if (score_r < SCORE_W'(WIN_SCORE)) score_r <= score_r + 1'b1;
            end else begin
              serve_dir <= 1'b1;
              if (score_l < SCORE_W'(WIN_SCORE)) score_l <= score_l + 1'b1;
            end
            if (match_won) begin
              st     <= OVER;
              winner <= goal_left ? 2'b10 : 2'b01;
            end else begin
              st         <= SERVE;
              ball_serve <= 1'b1;
              fcnt       <= '0;
            end
          end else if (pause_edge) begin
            st       <= PAUSE;
            ball_run <= 1'b0;
          end
`ifdef PONG_SPEEDUP_EN
          else if (paddle_hit) begin
            if (hcnt == HC_W'(HITS_PER_STEP - 1)) begin
              hcnt <= '0;
              if (speed != 3'd7) speed <= speed + 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
`endif
        end
        PAUSE: begin
          if (pause_edge) begin
            st       <= PLAY;
            ball_run <= 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          ball_run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  localparam int WIN = 7;
  localparam int SF  = 4;
  localparam int HPS = 4;
`ifdef PONG_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic       goal_left = 1'b0, goal_right = 1'b0, paddle_hit = 1'b0;
  logic       ball_run, ball_serve, serve_dir;
  logic [3:0] score_l, score_r;
  logic [2:0] speed;
  logic [1:0] winner;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .SCORE_W(4), .HITS_PER_STEP(HPS)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .goal_left(goal_left), .goal_right(goal_right),
    .paddle_hit(paddle_hit), .ball_run(ball_run), .ball_serve(ball_serve),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r), .speed(speed),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: match-level bookkeeping in plain integers.
  // phase: 0 idle, 1 waiting to serve, 2 rally, 3 paused, 4 match over.
  int m_phase, m_sl, m_sr, m_win, m_frames, m_hits_since;
  int m_run, m_serve, m_dir;
  int m_prev_start, m_prev_pause;

  function automatic int m_speed();
    int s;
    if (!SPEEDUP) return 3;
    s = 3 + m_hits_since / HPS;
    return (s > 7) ? 7 : s;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_frames = 0; m_hits_since = 0;
    m_run = 0; m_serve = 0; m_dir = 0; m_prev_start = 0; m_prev_pause = 0;
  endtask

  task automatic model_step(input int s, input int p, input int t,
                            input int gl, input int gr, input int h);
    bit s_rise, p_rise;
    s_rise = (s == 1) && (m_prev_start == 0);
    p_rise = (p == 1) && (m_prev_pause == 0);
    m_prev_start = s;
    m_prev_pause = p;
    m_serve = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (s_rise) begin
        m_phase = 1; m_sl = 0; m_sr = 0; m_win = 0;
        m_frames = 0; m_hits_since = 0; m_serve = 1;
      end
    end else if (m_phase == 1) begin
      if (t) begin
        m_frames++;
        if (m_frames == SF) begin m_phase = 2; m_run = 1; end
      end
    end else if (m_phase == 2) begin
      if (gl || gr) begin
        m_run = 0; m_hits_since = 0;
        if (gl) begin m_sr++; m_dir = 0; end
        else    begin m_sl++; m_dir = 1; end
        if (m_sl == WIN || m_sr == WIN) begin
          m_phase = 4;
          m_win = (m_sl == WIN) ? 1 : 2;
        end else begin
          m_phase = 1; m_serve = 1; m_frames = 0;
        end
      end else if (p_rise) begin
        m_phase = 3; m_run = 0;
      end else if (h) begin
        m_hits_since++;
      end
    end else if (m_phase == 3) begin
      if (p_rise) begin m_phase = 2; m_run = 1; end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("state",      int'(state),      m_phase);
    chk("ball_run",   int'(ball_run),   m_run);
    chk("ball_serve", int'(ball_serve), m_serve);
    chk("serve_dir",  int'(serve_dir),  m_dir);
    chk("score_l",    int'(score_l),    m_sl);
    chk("score_r",    int'(score_r),    m_sr);
    chk("speed",      int'(speed),      m_speed());
    chk("winner",     int'(winner),     m_win);
  endtask

  // One clock: drive inputs, let the edge happen, step the model, settle.
  task automatic cyc(input logic s, input logic p, input logic t,
                     input logic l, input logic r, input logic h);
    start_btn = s; pause_btn = p; frame_tick = t;
    goal_left = l; goal_right = r; paddle_hit = h;
    @(posedge clk);
    model_step(int'(s), int'(p), int'(t), int'(l), int'(r), int'(h));
    #1;
  endtask

  typedef struct {
    logic st, pa, tk, gl, gr;
    int   e_state, e_run, e_serve, e_dir, e_sl, e_sr, e_win;
  } vec_t;

  vec_t tbl[18];

  initial begin
    //            st pa tk gl gr   state run srv dir sl sr win
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1,0,1,0, 0,0,0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1,0,0,0, 0,0,0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,0,0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,0,0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,0,0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2,1,0,0, 0,0,0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1,0,1,0, 0,1,0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1,0,0,0, 0,1,0};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,1,0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,1,0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1,0,0,0, 0,1,0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2,1,0,0, 0,1,0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3,0,0,0, 0,1,0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 3,0,0,0, 0,1,0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 2,1,0,0, 0,1,0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2,1,0,0, 0,1,0};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1,0,1,1, 1,1,0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1,0,0,1, 1,1,0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",  int'(state), 0);
    chk("rst_run",    int'(ball_run), 0);
    chk("rst_serve",  int'(ball_serve), 0);
    chk("rst_dir",    int'(serve_dir), 0);
    chk("rst_scores", int'({score_l, score_r}), 0);
    chk("rst_speed",  int'(speed), 3);
    chk("rst_winner", int'(winner), 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_tick_ignored", int'(state), 0);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].st, tbl[i].pa, tbl[i].tk, tbl[i].gl, tbl[i].gr, 1'b0);
      chk($sformatf("v%0d_state", i), int'(state),      tbl[i].e_state);
      chk($sformatf("v%0d_run", i),   int'(ball_run),   tbl[i].e_run);
      chk($sformatf("v%0d_serve", i), int'(ball_serve), tbl[i].e_serve);
      chk($sformatf("v%0d_dir", i),   int'(serve_dir),  tbl[i].e_dir);
      chk($sformatf("v%0d_sl", i),    int'(score_l),    tbl[i].e_sl);
      chk($sformatf("v%0d_sr", i),    int'(score_r),    tbl[i].e_sr);
      chk($sformatf("v%0d_win", i),   int'(winner),     tbl[i].e_win);
    end

    // Left player wins: six more goal_right rallies from 1:1.
    for (int g = 0; g < 6; g++) begin
      repeat (SF) cyc(0, 0, 1, 0, 0, 0);
      chk("rally_play", int'(state), 2);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("over_state",  int'(state), 4);
    chk("over_winner", int'(winner), 1);
    chk("over_run",    int'(ball_run), 0);
    chk("over_sl",     int'(score_l), 7);
    chk("over_sr",     int'(score_r), 1);
    cyc(0, 1, 0, 1, 0, 0);
    chk("over_goal_ignored", int'(score_r), 1);
    chk("over_pause_ignored", int'(state), 4);
    cyc(1, 0, 0, 0, 0, 0);
    chk("restart_state", int'(state), 1);
    chk("restart_serve", int'(ball_serve), 1);
    chk("restart_sl",    int'(score_l), 0);
    chk("restart_win",   int'(winner), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("serve_one_cycle", int'(ball_serve), 0);

    // Speed ramp from paddle hits.
    repeat (SF) cyc(0, 0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    chk("speed_4hits", int'(speed), SPEEDUP ? 4 : 3);
    repeat (16) cyc(0, 0, 0, 0, 0, 1);
    chk("speed_20hits", int'(speed), SPEEDUP ? 7 : 3);
    cyc(0, 0, 0, 1, 0, 0);
    chk("speed_after_goal", int'(speed), 3);
    chk("dir_after_goal_left", int'(serve_dir), 0);

    // Randomised play against the reference model, with a mid-match reset.
    for (int k = 0; k < 3000; k++) begin
      cyc(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 24) == 0),
          logic'($urandom_range(0, 2) == 0),   logic'($urandom_range(0, 9) == 0),
          logic'($urandom_range(0, 9) == 0),   logic'($urandom_range(0, 3) == 0));
      check_model();
      if (k == 1500) begin
        start_btn = 0; pause_btn = 0; frame_tick = 0;
        goal_left = 0; goal_right = 0; paddle_hit = 0;
        #3 reset = 1'b1;
        model_reset();
        #1 check_model();
        @(posedge clk);
        #1 reset = 1'b0;
        check_model();
        cyc(1, 0, 0, 0, 0, 0);
        check_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
